// File: rtl/fft_pkg.sv
// Shared defaults and types for the FFT output peak-detect path.
package fft_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_FFT_N      = 16;
    localparam int unsigned DEF_QUANT_BITS = 14;

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_DRAIN = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    typedef logic [2*DEF_DATA_WIDTH-1:0] mag_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Combinational squared magnitude (re^2 + im^2) >> QUANT_BITS, truncated.
module fft_mag_sq
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int QUANT_BITS = DEF_QUANT_BITS
) (
    input  logic signed [DATA_WIDTH-1:0]   i_re,
    input  logic signed [DATA_WIDTH-1:0]   i_im,
    output logic        [2*DATA_WIDTH-1:0] o_mag
);

    logic signed [2*DATA_WIDTH-1:0] w_re_sq;
    logic signed [2*DATA_WIDTH-1:0] w_im_sq;
    logic        [2*DATA_WIDTH-1:0] w_sum;

    assign w_re_sq = (2*DATA_WIDTH)'(i_re) * (2*DATA_WIDTH)'(i_re);
    assign w_im_sq = (2*DATA_WIDTH)'(i_im) * (2*DATA_WIDTH)'(i_im);

    // Both squares are non-negative, so the unsigned sum peaks at 2^(2W-1) and cannot wrap.
    assign w_sum = $unsigned(w_re_sq) + $unsigned(w_im_sq);
    assign o_mag = w_sum >> QUANT_BITS;

endmodule

// File: rtl/fft_peak_detect.sv
// Drains FFT output frames, tracks the strongest bin and emits one (bin, mag) record per frame.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FFT_N      = DEF_FFT_N,
    parameter int QUANT_BITS = DEF_QUANT_BITS,
    parameter int IDX_WIDTH  = $clog2(FFT_N)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_real_empty,
    input  logic                         in_imag_empty,
    output logic                         in_rd_en,
    input  logic signed [DATA_WIDTH-1:0] in_real_dout,
    input  logic signed [DATA_WIDTH-1:0] in_imag_dout,
    input  logic                         out_full,
    output logic                         out_wr_en,
    output logic [IDX_WIDTH-1:0]         out_peak_bin,
    output logic [2*DATA_WIDTH-1:0]      out_peak_mag
);

    state_t                        r_state;
    logic [IDX_WIDTH-1:0]          r_cnt;
    logic                          r_s1_valid;
    logic signed [DATA_WIDTH-1:0]  r_s1_re;
    logic signed [DATA_WIDTH-1:0]  r_s1_im;
    logic [IDX_WIDTH-1:0]          r_s1_idx;
    logic [2*DATA_WIDTH-1:0]       r_best_mag;
    logic [IDX_WIDTH-1:0]          r_best_idx;

    logic                          w_pop;
    logic                          w_last;
    logic [2*DATA_WIDTH-1:0]       w_mag;

    // Gating with reset keeps the FIFOs untouched while the block is held in reset.
    assign w_pop     = !reset && (r_state == S_READ) && !in_real_empty && !in_imag_empty;
    assign w_last    = (r_cnt == IDX_WIDTH'(FFT_N - 1));
    assign in_rd_en  = w_pop;
    assign out_wr_en = !reset && (r_state == S_WRITE) && !out_full;

    assign out_peak_bin = r_best_idx;
    assign out_peak_mag = r_best_mag;

    fft_mag_sq #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUANT_BITS (QUANT_BITS)
    ) u_mag_sq (
        .i_re  (r_s1_re),
        .i_im  (r_s1_im),
        .o_mag (w_mag)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_READ;
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
            r_s1_idx   <= '0;
            r_best_mag <= '0;
            r_best_idx <= '0;
        end else begin
            r_s1_valid <= w_pop;
            if (w_pop) begin
                r_s1_re  <= in_real_dout;
                r_s1_im  <= in_imag_dout;
                r_s1_idx <= r_cnt;
                r_cnt    <= r_cnt + 1'b1;
            end

            // Bin 0 reloads the tracker; strict compare keeps the lowest index on ties.
            if (r_s1_valid && ((r_s1_idx == '0) || (w_mag > r_best_mag))) begin
                r_best_mag <= w_mag;
                r_best_idx <= r_s1_idx;
            end

            case (r_state)
                S_READ:  if (w_pop && w_last) r_state <= S_DRAIN;
                S_DRAIN: r_state <= S_WRITE;
                S_WRITE: if (!out_full) r_state <= S_READ;
                default: r_state <= S_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed and randomized bench for fft_peak_detect with a frame-level peak reference model.
module tb_fft_peak_detect;
    import fft_pkg::*;

    localparam int DW = 32;
    localparam int N  = 16;
    localparam int QB = 14;
    localparam int IW = $clog2(N);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_real_empty;
    logic          in_imag_empty;
    logic          in_rd_en;
    logic [DW-1:0] in_real_dout;
    logic [DW-1:0] in_imag_dout;
    logic          out_full;
    logic          out_wr_en;
    logic [IW-1:0] out_peak_bin;
    mag_t          out_peak_mag;

    logic [DW-1:0] q_re [0:4095];
    logic [DW-1:0] q_im [0:4095];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    logic          fifo_empty;
    logic          manual_empty = 1'b0;
    logic          manual_full  = 1'b0;
    logic          rand_bub     = 1'b0;
    logic          rand_full    = 1'b0;
    logic          bub_bit      = 1'b0;
    logic          full_bit     = 1'b0;
    logic          flush        = 1'b0;
    int unsigned   cyc          = 0;
    int unsigned   last_pop_cyc = 0;
    int unsigned   pop_cnt      = 0;
    int unsigned   wr_cnt       = 0;
    int unsigned   writes_seen  = 0;
    int            n_vec        = 0;
    int            n_fail       = 0;
    int            cur_re [N];
    int            cur_im [N];
    int            exp_bin [$];
    logic [63:0]   exp_mag [$];

    always #5 clock = ~clock;

    assign fifo_empty    = (rd_ptr == wr_ptr);
    assign in_real_empty = fifo_empty || manual_empty || (rand_bub && bub_bit);
    assign in_imag_empty = in_real_empty;
    assign in_real_dout  = q_re[rd_ptr[11:0]];
    assign in_imag_dout  = q_im[rd_ptr[11:0]];
    assign out_full      = manual_full || (rand_full && full_bit);

    fft_peak_detect #(
        .DATA_WIDTH (DW),
        .FFT_N      (N),
        .QUANT_BITS (QB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_real_empty (in_real_empty),
        .in_imag_empty (in_imag_empty),
        .in_rd_en      (in_rd_en),
        .in_real_dout  (in_real_dout),
        .in_imag_dout  (in_imag_dout),
        .out_full      (out_full),
        .out_wr_en     (out_wr_en),
        .out_peak_bin  (out_peak_bin),
        .out_peak_mag  (out_peak_mag)
    );

    // Show-ahead FIFO pair and write monitor.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (in_rd_en) begin
            rd_ptr       <= rd_ptr + 1;
            pop_cnt      <= pop_cnt + 1;
            last_pop_cyc <= cyc;
        end
        if (out_wr_en) wr_cnt <= wr_cnt + 1;
    end

    always @(negedge clock) begin
        bub_bit  <= ($urandom_range(0, 2) == 0);
        full_bit <= ($urandom_range(0, 1) == 0);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bin_mag(input int re, input int im);
        longint r = re;
        longint i = im;
        return (unsigned'(r * r) + unsigned'(i * i)) >> QB;
    endfunction

    // Reference: largest magnitude in the frame, reported at its first occurrence.
    task automatic model_peak(output int pb, output logic [63:0] pm);
        logic [63:0] mags [N];
        pm = '0;
        pb = 0;
        for (int k = 0; k < N; k++) begin
            mags[k] = bin_mag(cur_re[k], cur_im[k]);
            if (mags[k] > pm) pm = mags[k];
        end
        for (int k = N - 1; k >= 0; k--) if (mags[k] == pm) pb = k;
    endtask

    task automatic push_frame(input bit with_exp);
        int          pb;
        logic [63:0] pm;
        for (int k = 0; k < N; k++) begin
            q_re[wr_ptr[11:0]] = cur_re[k];
            q_im[wr_ptr[11:0]] = cur_im[k];
            wr_ptr++;
        end
        if (with_exp) begin
            model_peak(pb, pm);
            exp_bin.push_back(pb);
            exp_mag.push_back(pm);
        end
    endtask

    task automatic clear_frame(input int re, input int im);
        for (int k = 0; k < N; k++) begin
            cur_re[k] = re;
            cur_im[k] = im;
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
                0: begin cur_re[k] = int'($urandom); cur_im[k] = int'($urandom); end
                1: begin
                    cur_re[k] = int'($urandom_range(0, 2000000)) - 1000000;
                    cur_im[k] = int'($urandom_range(0, 2000000)) - 1000000;
                end
                2: begin
                    cur_re[k] = (k > 0) ? cur_re[k-1] : 0;
                    cur_im[k] = (k > 0) ? cur_im[k-1] : 0;
                end
                default: begin cur_re[k] = 0; cur_im[k] = 0; end
            endcase
        end
    endtask

    task automatic wait_pops(input int unsigned target);
        for (int i = 0; i < 500 && pop_cnt < target; i++) tick();
        chk("pop_budget", 64'(pop_cnt >= target), 64'd1);
    endtask

    task automatic check_write(input string tag);
        bit          got = 1'b0;
        int          eb  = -1;
        logic [63:0] em  = '1;
        for (int i = 0; i < 600; i++) begin
            if (out_wr_en === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (exp_bin.size() > 0) begin
            eb = exp_bin.pop_front();
            em = exp_mag.pop_front();
        end
        chk({tag, "_write_seen"}, 64'(got), 64'd1);
        chk({tag, "_peak_bin"}, 64'(out_peak_bin), 64'(eb));
        chk({tag, "_peak_mag"}, out_peak_mag, em);
        writes_seen++;
        tick();
    endtask

    initial begin
        int unsigned base;
        int unsigned wr_before;

        // Reset with data waiting: nothing may be popped.
        reset = 1'b1;
        repeat (3) tick();
        clear_frame(0, 0);
        cur_re[5] = 16384;
        push_frame(1'b1);
        tick();
        chk("rst_rd_en", 64'(in_rd_en), 64'd0);
        chk("rst_wr_en", 64'(out_wr_en), 64'd0);
        chk("rst_peak_bin", 64'(out_peak_bin), 64'd0);
        chk("rst_peak_mag", out_peak_mag, 64'd0);
        chk("rst_no_pop", 64'(pop_cnt), 64'd0);
        reset = 1'b0;

        // Single-bin peak, plus write latency after the last pop.
        for (int i = 0; i < 100 && out_wr_en !== 1'b1; i++) tick();
        chk("s1_latency", 64'(cyc - last_pop_cyc), 64'd2);
        check_write("s1");
        chk("s1_wr_cnt", 64'(wr_cnt), 64'd1);

        // Tie between bins 3 and 9.
        clear_frame(0, 0);
        cur_re[3] = 100; cur_im[3] = -100;
        cur_re[9] = 100; cur_im[9] = -100;
        push_frame(1'b1);
        check_write("s2_tie");

        // Most negative samples at the last bin.
        clear_frame(1, 1);
        cur_re[15] = int'(32'h8000_0000);
        cur_im[15] = int'(32'h8000_0000);
        push_frame(1'b1);
        check_write("s3_extreme");

        clear_frame(0, 0);
        push_frame(1'b1);
        check_write("s4_zero");
        chk("s4_wr_cnt", 64'(wr_cnt), 64'(writes_seen));

        // Downstream full at frame end, with the next frame already waiting.
        manual_full = 1'b1;
        base = pop_cnt;
        rand_frame();
        push_frame(1'b1);
        rand_frame();
        push_frame(1'b1);
        wait_pops(base + N);
        tick();
        wr_before = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("hold_wr_en", 64'(out_wr_en), 64'd0);
            chk("hold_rd_en", 64'(in_rd_en), 64'd0);
            if (i == 0 || i == 9) begin
                chk("hold_peak_bin", 64'(out_peak_bin), 64'(exp_bin[0]));
                chk("hold_peak_mag", out_peak_mag, exp_mag[0]);
            end
            tick();
        end
        chk("hold_no_pop", 64'(pop_cnt), 64'(base + N));
        chk("hold_no_write", 64'(wr_cnt), 64'(wr_before));
        manual_full = 1'b0;
        #1;
        check_write("hold_release");
        chk("hold_one_write", 64'(wr_cnt), 64'(wr_before + 1));
        check_write("hold_next");

        // Bubbles every other cycle, reset after 7 pops, then a clean frame.
        wr_before = wr_cnt;
        base = pop_cnt;
        for (int k = 0; k < N; k++) begin
            cur_re[k] = 2000000000 - k;
            cur_im[k] = 1000000;
        end
        push_frame(1'b0);
        for (int i = 0; i < 200 && (pop_cnt - base) < 7; i++) begin
            manual_empty = !manual_empty;
            tick();
        end
        reset = 1'b1;
        flush = 1'b1;
        manual_empty = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        flush = 1'b0;
        chk("bub_pops", 64'(pop_cnt - base), 64'd7);
        chk("bub_no_write", 64'(wr_cnt), 64'(wr_before));
        chk("post_rst_peak_mag", out_peak_mag, 64'd0);
        clear_frame(0, 0);
        cur_re[5] = 16384;
        push_frame(1'b1);
        check_write("post_rst");
        chk("post_rst_one_write", 64'(wr_cnt), 64'(wr_before + 1));

        // Random frames with random bubbles and downstream backpressure.
        rand_bub  = 1'b1;
        rand_full = 1'b1;
        for (int f = 0; f < 6; f++) begin
            rand_frame();
            push_frame(1'b1);
        end
        for (int f = 0; f < 6; f++) check_write("rand");
        rand_bub  = 1'b0;
        rand_full = 1'b0;
        repeat (4) tick();
        chk("final_wr_cnt", 64'(wr_cnt), 64'(writes_seen));
        chk("final_drained", 64'(rd_ptr), 64'(wr_ptr));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
